// File: rtl/lamp_fpu_exp_mul_arb_pkg.sv
// Shared types and the round-robin pick helper for the exponential unit's multiply arbiter.
package lamp_fpu_exp_mul_arb_pkg;

  localparam int LAMP_FLOAT_DW = 16;
  localparam int MUL_NREQ_MAX  = 8;

  typedef logic [$clog2(MUL_NREQ_MAX)-1:0] mulReqId_t;
  typedef struct packed {logic valid; mulReqId_t id;} mulTag_t;
  typedef struct packed {logic hit; mulReqId_t id;} mulPick_t;

  // Rotate elig so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic mulPick_t FUNC_rrPick(input logic [MUL_NREQ_MAX-1:0] elig,
                                           input mulReqId_t ptr, input int nreq);
    logic [MUL_NREQ_MAX-1:0] rot;
    mulPick_t                r;
    rot = '0;
    r   = '0;
    for (int i = 0; i < MUL_NREQ_MAX; i++)
      if (i < nreq) rot[i] = elig[mulReqId_t'((int'(ptr) + i) % nreq)];
    for (int i = MUL_NREQ_MAX-1; i >= 0; i--)
      if (rot[i]) begin
        r.hit = 1'b1;
        r.id  = mulReqId_t'((int'(ptr) + i) % nreq);
      end
    return r;
  endfunction

endpackage

// File: rtl/lamp_fpu_exp_mul_arb_pick.sv
// Combinational round-robin picker over NREQ eligibility bits.
module lamp_fpu_rr_pick
  import lamp_fpu_exp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] elig,
  input  mulReqId_t       ptr,
  output logic            hit,
  output mulReqId_t       id
);

  logic [MUL_NREQ_MAX-1:0] elig_ext;
  mulPick_t                pick;

  always_comb begin
    elig_ext           = '0;
    elig_ext[NREQ-1:0] = elig;
    pick               = FUNC_rrPick(elig_ext, ptr, NREQ);
  end

  assign hit = pick.hit;
  assign id  = pick.id;

endmodule

// File: rtl/lamp_fpu_exp_mul_arb.sv
// Round-robin sharing of one bfloat16 multiply pipe among NREQ requesters, with ID tags
// tracked through the fixed-latency pipe and per-requester result holding registers.
module lamp_fpu_exp_mul_arb
  import lamp_fpu_exp_mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int DW      = LAMP_FLOAT_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0][DW-1:0]  op1_i,
  input  logic [NREQ-1:0][DW-1:0]  op2_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     doMul_o,
  output logic [DW-1:0]            mulOp1_o,
  output logic [DW-1:0]            mulOp2_o,
  input  logic                     mulValid_i,
  input  logic [DW-1:0]            mulRes_i,
  output logic [NREQ-1:0]          rspValid_o,
  output logic [NREQ-1:0][DW-1:0]  rspData_o,
  input  logic [NREQ-1:0]          rspReady_i,
  output logic                     busy_o,
  output logic                     errProt_o
);

  logic [NREQ-1:0] pend, elig, cap_vec, drop_vec, rel_vec;
  mulReqId_t       ptr, pick_id, ptr_nxt;
  logic            pick_hit;
  mulTag_t         tag_pipe [MUL_LAT];
  mulTag_t         tag_out;

  assign elig = req_i & ~pend;

  lamp_fpu_rr_pick #(.NREQ(NREQ)) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .hit  (pick_hit),
    .id   (pick_id)
  );

  always_comb begin
    gnt_o    = '0;
    mulOp1_o = '0;
    mulOp2_o = '0;
    for (int n = 0; n < NREQ; n++)
      if (pick_hit && pick_id == mulReqId_t'(n)) begin
        gnt_o[n] = 1'b1;
        mulOp1_o = op1_i[n];
        mulOp2_o = op2_i[n];
      end
  end

  assign doMul_o = |gnt_o;
  assign ptr_nxt = mulReqId_t'((int'(pick_id) + 1) % NREQ);
  assign tag_out = tag_pipe[MUL_LAT-1];

  // A valid tag leaving the pipe either captures the result or, if the pipe dropped it, frees the slot.
  always_comb begin
    cap_vec  = '0;
    drop_vec = '0;
    for (int n = 0; n < NREQ; n++)
      if (tag_out.valid && tag_out.id == mulReqId_t'(n)) begin
        cap_vec[n]  = mulValid_i;
        drop_vec[n] = ~mulValid_i;
      end
    rel_vec = rspValid_o & rspReady_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr        <= '0;
      pend       <= '0;
      rspValid_o <= '0;
      rspData_o  <= '0;
      errProt_o  <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      if (doMul_o) ptr <= ptr_nxt;
      tag_pipe[0] <= {doMul_o, pick_id};
      for (int i = 1; i < MUL_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (|drop_vec) errProt_o <= 1'b1;
      // Grant needs pend=0 while release/drop need pend=1, so the set and clear never collide.
      pend       <= (pend & ~(rel_vec | drop_vec)) | gnt_o;
      rspValid_o <= (rspValid_o & ~rel_vec) | cap_vec;
      for (int n = 0; n < NREQ; n++)
        if (cap_vec[n]) rspData_o[n] <= mulRes_i;
    end
  end

  assign busy_o = |pend;

endmodule

// File: tb/tb_lamp_fpu_exp_mul_arb.sv
// Bench for the multiply arbiter: behavioural bfloat16 multiplier (2-cycle) and per-requester scoreboard.
module tb_lamp_fpu_exp_mul_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int DW   = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_i;
  logic [NREQ-1:0][DW-1:0] op1_i, op2_i;
  logic [NREQ-1:0]         gnt_o;
  logic                    doMul_o;
  logic [DW-1:0]           mulOp1_o, mulOp2_o;
  logic                    mulValid_i;
  logic [DW-1:0]           mulRes_i;
  logic [NREQ-1:0]         rspValid_o;
  logic [NREQ-1:0][DW-1:0] rspData_o;
  logic [NREQ-1:0]         rspReady_i;
  logic                    busy_o, errProt_o;

  always #5 clk = ~clk;

  lamp_fpu_exp_mul_arb #(.NREQ(NREQ), .MUL_LAT(LAT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op1_i(op1_i), .op2_i(op2_i),
    .gnt_o(gnt_o), .doMul_o(doMul_o), .mulOp1_o(mulOp1_o), .mulOp2_o(mulOp2_o),
    .mulValid_i(mulValid_i), .mulRes_i(mulRes_i), .rspValid_o(rspValid_o),
    .rspData_o(rspData_o), .rspReady_i(rspReady_i), .busy_o(busy_o), .errProt_o(errProt_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Normal-operand bfloat16 multiply, round to nearest even.
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    int          e;
    logic [15:0] p;
    logic [8:0]  m;
    logic        g, st;
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    p = {1'b1, a[6:0]} * {1'b1, b[6:0]};
    if (p[15]) begin
      m = {1'b0, p[15:8]}; g = p[7]; st = |p[6:0]; e++;
    end else begin
      m = {1'b0, p[14:7]}; g = p[6]; st = |p[5:0];
    end
    if (g && (st || m[0])) m++;
    if (m[8]) begin m = m >> 1; e++; end
    return {a[15] ^ b[15], e[7:0], m[6:0]};
  endfunction

  // Multiply pipe model; kill suppresses the valid to provoke a protocol error.
  logic        mp_v0 = 1'b0, mp_v1 = 1'b0, kill = 1'b0;
  logic [15:0] mp_d0 = '0, mp_d1 = '0;
  always @(posedge clk) begin
    mp_v0 <= doMul_o;
    mp_d0 <= bf16_mul(mulOp1_o, mulOp2_o);
    mp_v1 <= mp_v0;
    mp_d1 <= mp_d0;
  end
  assign mulValid_i = mp_v1 & ~kill;
  assign mulRes_i   = mp_d1;

  // Scoreboard: expected product queued at grant, checked when rspValid rises.
  logic [15:0]     exp_q [NREQ][$];
  logic [NREQ-1:0] prev_v = '0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < NREQ; n++) exp_q[n].delete();
    end else begin
      for (int n = 0; n < NREQ; n++) begin
        if (gnt_o[n]) exp_q[n].push_back(bf16_mul(op1_i[n], op2_i[n]));
        if (rspValid_o[n] && !prev_v[n]) begin
          chk($sformatf("rsp%0d_expected", n), 32'(exp_q[n].size() > 0), 1);
          if (exp_q[n].size() > 0)
            chk($sformatf("rsp%0d_data", n), 32'(rspData_o[n]), 32'(exp_q[n].pop_front()));
        end
      end
    end
    prev_v <= rst ? rspValid_o : '0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; req_i = '0; rspReady_i = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic drain(input string tag);
    req_i = '0; rspReady_i = '1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!busy_o && rspValid_o == '0) break;
    end
    chk(tag, 32'({busy_o, rspValid_o}), 0);
    tick();
    rspReady_i = '0;
  endtask

  logic [NREQ-1:0] g2 [6];
  logic [15:0]     exp2;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    op1_i = '0; op2_i = '0; req_i = '0; rspReady_i = '0; rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_state", 32'({errProt_o, busy_o, rspValid_o, gnt_o, doMul_o}), 0);
    chk("rst_op", 32'({mulOp1_o, mulOp2_o}), 0);
    tick();
    rst = 1'b1;

    // 1: single request, latency and release
    req_i = 4'b0010; op1_i[1] = 16'h4000; op2_i[1] = 16'h4040;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt_o), 32'b0010);
    chk("t1_op", 32'({doMul_o, mulOp1_o, mulOp2_o}), {15'd0, 1'b1, 16'h4000} << 16 | 32'h4040);
    tick(); req_i = '0;
    @(negedge clk); chk("t1_early1", 32'(rspValid_o), 0);
    tick();
    @(negedge clk); chk("t1_early2", 32'(rspValid_o), 0);
    tick();
    @(negedge clk);
    chk("t1_vld", 32'(rspValid_o), 32'b0010);
    chk("t1_data", 32'(rspData_o[1]), 32'h40C0);
    chk("t1_busy", 32'(busy_o), 1);
    rspReady_i[1] = 1'b1;
    tick(); rspReady_i = '0;
    @(negedge clk);
    chk("t1_rel", 32'({busy_o, rspValid_o}), 0);

    // 2: all request, always ready; rotation from ptr 0
    do_reset();
    g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int n = 0; n < NREQ; n++) begin
      op1_i[n] = 16'h3F80 + 16'(n * 16'h0090);
      op2_i[n] = 16'h4010 + 16'(n * 16'h0023);
    end
    req_i = '1; rspReady_i = '1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("t2_gnt_c%0d", c), 32'(gnt_o), 32'(g2[c]));
      tick();
    end
    drain("t2_drain");

    // 3: backpressure blocks reissue until the release edge
    req_i = 4'b0100; op1_i[2] = 16'h4100; op2_i[2] = 16'hC030;
    @(negedge clk); chk("t3_gnt", 32'(gnt_o), 32'b0100);
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk); chk($sformatf("t3_block%0d", c), 32'(gnt_o), 0);
    end
    chk("t3_held", 32'(rspValid_o), 32'b0100);
    tick(); rspReady_i[2] = 1'b1;
    @(negedge clk); chk("t3_rel_cycle", 32'(gnt_o), 0);
    tick();
    @(negedge clk);
    chk("t3_released", 32'(rspValid_o), 0);
    chk("t3_regrant", 32'(gnt_o), 32'b0100);
    tick();
    drain("t3_drain");

    // 4: reset right after issue discards the op; stale pipe result ignored
    req_i = 4'b0001; op1_i[0] = 16'h3F80; op2_i[0] = 16'h3F80;
    @(negedge clk); chk("t4_gnt", 32'(gnt_o), 32'b0001);
    tick(); req_i = '0; rst = 1'b0;
    tick(); rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk($sformatf("t4_quiet%0d", c), 32'({errProt_o, busy_o, rspValid_o}), 0);
      tick();
    end

    // 5: dropped result raises sticky error and frees the slot
    req_i = 4'b1000; op1_i[3] = 16'h40A0; op2_i[3] = 16'h3FC0;
    @(negedge clk); chk("t5_gnt", 32'(gnt_o), 32'b1000);
    tick(); kill = 1'b1;
    tick();
    tick(); kill = 1'b0;
    @(negedge clk);
    chk("t5_err", 32'(errProt_o), 1);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_regrant", 32'(gnt_o), 32'b1000);
    void'(exp_q[3].pop_front());
    tick();
    drain("t5_drain");
    chk("t5_sticky", 32'(errProt_o), 1);

    // 6: capture id0, release id2 and issue id1 on one edge
    op1_i[2] = 16'h4040; op2_i[2] = 16'h4040;
    op1_i[0] = 16'h3FA0; op2_i[0] = 16'h4120;
    op1_i[1] = 16'hBF80; op2_i[1] = 16'h4200;
    exp2 = bf16_mul(16'h4040, 16'h4040);
    req_i = 4'b0100;
    @(negedge clk); chk("t6_gnt2", 32'(gnt_o), 32'b0100);
    tick(); req_i = 4'b0001;
    @(negedge clk); chk("t6_gnt0", 32'(gnt_o), 32'b0001);
    tick(); req_i = '0;
    tick(); req_i = 4'b0010; rspReady_i = 4'b0100;
    @(negedge clk);
    chk("t6_gnt1", 32'(gnt_o), 32'b0010);
    chk("t6_pre_vld", 32'(rspValid_o), 32'b0100);
    tick(); req_i = 4'b0100; rspReady_i = '0;
    @(negedge clk);
    chk("t6_vld", 32'(rspValid_o), 32'b0001);
    chk("t6_busy", 32'(busy_o), 1);
    chk("t6_hold2", 32'(rspData_o[2]), 32'(exp2));
    chk("t6_pend2_clr", 32'(gnt_o), 32'b0100);
    tick();
    drain("t6_drain");

    chk("q_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
